// File: rtl/eth_rx_pkg.sv
// Shared definitions for the ethernet receive frame controller: FSM states,
// broadcast address and status-word field positions.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    STREAM,
    DROP
  } state_t;

  localparam logic [47:0] ETH_BCAST_ADDR = 48'hffff_ffff_ffff;

  localparam int unsigned ERR_BIT    = 15;
  localparam int unsigned CNT_MSB    = 14;
  localparam int unsigned WORD_SHIFT = 3;

endpackage

// File: rtl/eth_rx_skid.sv
// Two-entry valid/ready buffer for frame words (64-bit data + last flag).
// free reports the entries available this cycle, crediting a same-cycle pop.
module eth_rx_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [1:0]  free
);

  logic [64:0] e0, e1;
  logic [1:0]  count;
  logic        pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = e0[63:0];
  assign out_last  = e0[64];
  assign free      = 2'd2 - count + {1'b0, pop};

  // e0 is always the head, so a stalled head never moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= {in_last, in_data};
          else               e1 <= {in_last, in_data};
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= {in_last, in_data};
          end else begin
            e0 <= e1;
            e1 <= {in_last, in_data};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Drains the receive MAC status/data FIFOs: delivers good frames, discards bad ones.
// Optional destination-address filter enabled by defining ETH_RX_MAC_FILTER_EN.
module eth_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_WORDS = 8,
  parameter logic [47:0] MAC_ADDR  = 48'h000000000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ctl_rd_en_out,
  input  logic [15:0] ctl_rd_d_in,
  input  logic        ctl_rd_empty_in,
  output logic        data_rd_en_out,
  input  logic [63:0] data_rd_d_in,
  input  logic        data_rd_empty_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [15:0] frames_ok_out,
  output logic [15:0] frames_drop_out
);

  state_t      state, state_nx;
  logic [11:0] remaining, hdr_words;
  logic        hdr_drop, rd_pending, rd_pending_last;
  logic        done_ok, done_drop, issue_ok, reject, sk_pop;
  logic        sk_in_valid, sk_in_last;
  logic [63:0] sk_in_data;
  logic [1:0]  sk_free, inflight;

  assign hdr_words = ctl_rd_d_in[CNT_MSB:WORD_SHIFT];
  assign hdr_drop  = ctl_rd_d_in[ERR_BIT] || (32'(hdr_words) < MIN_WORDS) || (hdr_words == 12'd0);
  assign sk_pop    = out_valid && out_ready;

`ifdef ETH_RX_MAC_FILTER_EN
  logic        pre, hold_valid, hold_last, hold_push;
  logic [63:0] hold_data;

  assign reject    = hold_valid && (hold_data[63:16] != MAC_ADDR) && (hold_data[63:16] != ETH_BCAST_ADDR);
  assign hold_push = hold_valid && !reject;
  // Only the first read may be outstanding until the held word is judged.
  assign issue_ok    = !pre || (!rd_pending && !hold_valid) || hold_push;
  assign sk_in_valid = (state == STREAM) && (hold_push || (rd_pending && !pre));
  assign sk_in_data  = hold_push ? hold_data : data_rd_d_in;
  assign sk_in_last  = hold_push ? hold_last : rd_pending_last;
  assign inflight    = {1'b0, rd_pending} + {1'b0, hold_push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= 1'b0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
    end else if (state == HDR) begin
      pre        <= 1'b1;
      hold_valid <= 1'b0;
    end else if ((state == STREAM) && pre) begin
      if (hold_valid) begin
        hold_valid <= 1'b0;
        pre        <= 1'b0;
      end else if (rd_pending) begin
        hold_valid <= 1'b1;
        hold_data  <= data_rd_d_in;
        hold_last  <= rd_pending_last;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^MAC_ADDR;
  assign reject      = 1'b0;
  assign issue_ok    = 1'b1;
  assign sk_in_valid = (state == STREAM) && rd_pending;
  assign sk_in_data  = data_rd_d_in;
  assign sk_in_last  = rd_pending_last;
  assign inflight    = {1'b0, rd_pending};
`endif

  always_comb begin
    state_nx       = state;
    ctl_rd_en_out  = 1'b0;
    data_rd_en_out = 1'b0;
    done_ok        = 1'b0;
    done_drop      = 1'b0;
    case (state)
      IDLE: begin
        if (!ctl_rd_empty_in) begin
          ctl_rd_en_out = rst_n;
          state_nx      = HDR;
        end
      end
      HDR: begin
        if (hdr_drop) begin
          if (hdr_words == 12'd0) begin
            done_drop = 1'b1;
            state_nx  = IDLE;
          end else begin
            state_nx = DROP;
          end
        end else begin
          state_nx = STREAM;
        end
      end
      STREAM: begin
        data_rd_en_out = issue_ok && !reject && !data_rd_empty_in &&
                         (remaining != 12'd0) && (sk_free > inflight);
        if (reject) begin
          state_nx = DROP;
        end else if (sk_pop && out_last) begin
          done_ok  = 1'b1;
          state_nx = IDLE;
        end
      end
      DROP: begin
        data_rd_en_out = !data_rd_empty_in && (remaining != 12'd0);
        if ((remaining == 12'd0) && !rd_pending) begin
          done_drop = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      remaining       <= '0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      frames_ok_out   <= '0;
      frames_drop_out <= '0;
    end else begin
      state <= state_nx;
      if (state == HDR)        remaining <= hdr_words;
      else if (data_rd_en_out) remaining <= remaining - 12'd1;
      rd_pending      <= data_rd_en_out;
      rd_pending_last <= data_rd_en_out && (remaining == 12'd1);
      if (done_ok)   frames_ok_out   <= frames_ok_out + 16'd1;
      if (done_drop) frames_drop_out <= frames_drop_out + 16'd1;
    end
  end

  eth_rx_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sk_in_valid),
    .in_data   (sk_in_data),
    .in_last   (sk_in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .free      (sk_free)
  );

endmodule
